// File: rtl/roi_shift_driver.sv
// roi_shift_driver: drives a serial-chain DUT harness through one full
// load/settle/capture/drain transaction per accepted start request.
//
// Sequence (cycle 0 is the first cycle after start is accepted):
//   FILL      0 .. DIN_N-1             shift vec_in into the DUT, stb=0
//   STB_LOAD  DIN_N                    stb=1 (DUT din <= vec_in)
//   SETTLE    DIN_N+1 .. 2*DIN_N-1     stb=0
//   STB_CAP   2*DIN_N                  stb=1 (DUT dout_shr <= dout)
//   DRAIN     2*DIN_N+1 .. 2*DIN_N+DOUT_N   capture dut_do serially
//   DONE      2*DIN_N+DOUT_N+1         done=1, vec_out updated
// di carries vec_in MSB-first and wraps cyclically through the end of DRAIN.
//
// Ports:
//   clk      clock, all logic on posedge
//   rst      synchronous active-high reset
//   start    transaction request, sampled only in IDLE
//   vec_in   parallel vector delivered to the DUT, latched on acceptance
//   vec_out  parallel vector captured from the DUT (registered)
//   busy     high in every state except IDLE
//   done     one-cycle pulse, vec_out valid from this cycle on
//   di       serial data to the DUT harness
//   stb      parallel-load strobe to the DUT harness
//   dut_do   serial data returned by the DUT harness

module roi_shift_driver #(
  parameter int unsigned DIN_N  = 256,
  parameter int unsigned DOUT_N = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIN_N-1:0]  vec_in,
  output logic [DOUT_N-1:0] vec_out,
  output logic              busy,
  output logic              done,
  output logic              di,
  output logic              stb,
  input  logic              dut_do
);

  localparam int unsigned MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int unsigned CNT_W = $clog2(MAX_N) + 1;

  // Last counter value of each multi-cycle state; counter restarts at 0 per state.
  localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(DIN_N - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DIN_N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DOUT_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STB_LOAD,
    S_SETTLE,
    S_STB_CAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DIN_N-1:0]  rot;
  logic [DOUT_N-1:0] cap;

  logic [DIN_N-1:0]  vec_in_rotl;
  logic [DIN_N-1:0]  rot_next;
  logic [DOUT_N-1:0] cap_next;
  logic              shifting;

  // rot always holds the bit pattern whose MSB is the next di value.
  assign vec_in_rotl = {vec_in[DIN_N-2:0], vec_in[DIN_N-1]};
  assign rot_next    = {rot[DIN_N-2:0], rot[DIN_N-1]};

  // Capture shifts dut_do into the LSB; first sample ends up in the MSB.
  assign cap_next = (cap << 1) | DOUT_N'(dut_do);

  // di keeps streaming the rotated vector from FILL through DRAIN.
  assign shifting = (state == S_FILL)   || (state == S_STB_LOAD) ||
                    (state == S_SETTLE) || (state == S_STB_CAP)  ||
                    (state == S_DRAIN);

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rot     <= '0;
      cap     <= '0;
      vec_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      di      <= 1'b0;
      stb     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (shifting) begin
        di  <= rot[DIN_N-1];
        rot <= rot_next;
      end

      case (state)
        S_IDLE: begin
          di   <= 1'b0;
          stb  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            // Cycle 0 must already present the MSB, so di is loaded here.
            di    <= vec_in[DIN_N-1];
            rot   <= vec_in_rotl;
            cap   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_FILL;
          end
        end

        S_FILL: begin
          if (cnt == FILL_LAST) begin
            cnt   <= '0;
            stb   <= 1'b1;
            state <= S_STB_LOAD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_STB_LOAD: begin
          stb   <= 1'b0;
          cnt   <= '0;
          state <= S_SETTLE;
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            stb   <= 1'b1;
            state <= S_STB_CAP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_STB_CAP: begin
          stb   <= 1'b0;
          cnt   <= '0;
          state <= S_DRAIN;
        end

        S_DRAIN: begin
          cap <= cap_next;
          if (cnt == DRAIN_LAST) begin
            // Final sample goes straight into vec_out on the DRAIN->DONE edge.
            vec_out <= cap_next;
            done    <= 1'b1;
            di      <= 1'b0;
            cnt     <= '0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          // start is ignored here; acceptance resumes from IDLE.
          busy  <= 1'b0;
          di    <= 1'b0;
          stb   <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          di    <= 1'b0;
          stb   <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/roi_shift_driver.md
ROI_SHIFT_DRIVER -- requirements
Module: roi_shift_driver

Interface
REQ-001 Parameter DIN_N, default 256, length of the DUT serial input chain; legal range 2..4096.
REQ-002 Parameter DOUT_N, default 256, length of the DUT serial output chain; legal range 1..4096.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request one transaction; sampled only in IDLE.
REQ-006 vec_in  in  DIN_N  parallel vector to deliver to the DUT; latched on start acceptance.
REQ-007 vec_out  out  DOUT_N  parallel vector captured from the DUT; registered.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse; vec_out valid from this cycle on.
REQ-010 di  out  1  serial data to the DUT harness di input; registered.
REQ-011 stb  out  1  parallel-load strobe to the DUT harness stb input; registered.
REQ-012 dut_do  in  1  serial data from the DUT harness do output.

Function
REQ-013 DUT contract: per posedge, din_shr <= {din_shr, di}; on stb, din <= din_shr and dout_shr <= dout; otherwise dout_shr shifts left; do = dout_shr[DOUT_N-1].
REQ-014 States: IDLE, FILL, STB_LOAD, SETTLE, STB_CAP, DRAIN, DONE.
REQ-015 IDLE with start=1 at a posedge: latch vec_in into a rotate register, counter=0, go FILL; cycle 0 is the first FILL cycle.
REQ-016 Relative cycle k (k=0 first FILL cycle): di = vec_in[DIN_N-1-(k mod DIN_N)] for all k from 0 to 2*DIN_N+DOUT_N inclusive; i.e. MSB first, cyclic, never zero-padded.
REQ-017 FILL lasts cycles 0..DIN_N-1, stb=0.
REQ-018 STB_LOAD is cycle DIN_N, stb=1 (DUT din <= vec_in).
REQ-019 SETTLE lasts cycles DIN_N+1..2*DIN_N-1, stb=0.
REQ-020 STB_CAP is cycle 2*DIN_N, stb=1 (din reloaded with identical vec_in; dout_shr captures dout).
REQ-021 DRAIN lasts cycles 2*DIN_N+1..2*DIN_N+DOUT_N; each posedge shifts dut_do into the LSB of an internal capture register; first sample = dout[DOUT_N-1].
REQ-022 DONE is cycle 2*DIN_N+DOUT_N+1: done=1, vec_out = capture register (loaded at the DRAIN->DONE edge), di=0, stb=0; next state IDLE.
REQ-023 stb is high in exactly two cycles per transaction; never high in IDLE or DONE.
REQ-024 IDLE: di=0, stb=0, busy=0.
REQ-025 start while busy, including during DONE, is ignored; no queuing.
REQ-026 start held high continuously: next transaction accepted in the first IDLE cycle after DONE; vec_in is sampled then.
REQ-027 vec_in changes after acceptance have no effect on the running transaction.
REQ-028 vec_out changes only at the DRAIN->DONE edge and holds between transactions.
REQ-029 Counter width clog2(max(DIN_N,DOUT_N))+1; no wrap within any state.

Reset
REQ-030 rst=1 at a posedge forces IDLE; di=0, stb=0, busy=0, done=0, vec_out=0, counter=0, rotate and capture registers=0.
REQ-031 rst has priority over start and all state transitions.
REQ-032 rst mid-transaction aborts with no done pulse; vec_out is cleared to 0.

Verification
REQ-033 Bench instantiates the DUT harness with DIN_N=DOUT_N=8 and a roi model where dout=~din, registered one cycle.
REQ-034 Reset: rst high 3 cycles -> di=0, stb=0, busy=0, done=0, vec_out=8'h00.
REQ-035 start with vec_in=8'hA5 -> di over cycles 0..7 = 1,0,1,0,0,1,0,1; stb high only in cycles 8 and 16; done in cycle 25; vec_out=8'h5A.
REQ-036 start pulse during cycle 10, then vec_in=8'hFF -> transaction unaffected; vec_out=8'h5A; exactly one done.
REQ-037 rst asserted in cycle 20 (DRAIN) -> IDLE next cycle, no done, vec_out=8'h00, stb=0; then start with 8'h3C -> vec_out=8'hC3.
REQ-038 start held high over two transactions, vec_in=8'h01 then 8'h80 -> done pulses 27 cycles apart; vec_out 8'hFE then 8'h7F.
